// File: rtl/key_scan_pkg.sv
// key_scan_pkg
// Shared constants and types for the keypad scanner.
//   NUM_COLS / NUM_ROWS : keypad matrix geometry (4 columns, 5 rows)
//   CODE_W              : width of a key code (codes 1..20, 0 = none, 31 = multi)
//   KEY_NONE / KEY_MULTI: reserved frame/debounce codes
//   scan_state_t        : column-scan FSM states
//   key_code_of()       : flat matrix bit index (row*4 + col) to key code
package key_scan_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 5;
  localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;
  localparam int CODE_W   = 5;

  localparam logic [CODE_W-1:0] KEY_NONE  = 5'd0;
  localparam logic [CODE_W-1:0] KEY_MULTI = 5'd31;

  typedef enum logic {
    COL_DWELL,
    FRAME_EVAL
  } scan_state_t;

  // Frame bits are laid out as row*NUM_COLS + col, so the key code is simply index + 1.
  function automatic logic [CODE_W-1:0] key_code_of(input logic [CODE_W-1:0] idx);
    return idx + CODE_W'(1);
  endfunction

endpackage

// File: rtl/key_scan_sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for asynchronous level inputs.
//   i_clk  : clock, rising edge
//   i_rstn : synchronous active-low reset, clears both stages
//   i_d    : asynchronous input bus (WIDTH bits)
//   o_q    : synchronized output, two clocks behind i_d
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_scan.sv
// key_scan
// Matrix keypad scanner: walks a one-hot column drive across 4 columns, samples
// the 5 row lines at the end of each column dwell, encodes one key code per scan
// frame, debounces it over DEB_SCANS frames and reports debounced presses.
//   i_clk       : clock, rising edge
//   i_rstn      : synchronous active-low reset
//   i_key_in    : row lines, bit r high = key in row r of the driven column closed
//   o_key_out   : column drive, one-hot, all zero during frame evaluation
//   o_key_code  : last debounced key code (1..20), 0 until the first press
//   o_key_valid : one-cycle pulse on each debounced press (including key slides)
//   o_key_held  : high while the debounced state is a single valid key
module key_scan
  import key_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 10000,
  parameter int DEB_SCANS = 3
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [NUM_ROWS-1:0] i_key_in,
  output logic [NUM_COLS-1:0] o_key_out,
  output logic [CODE_W-1:0]   o_key_code,
  output logic                o_key_valid,
  output logic                o_key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEB_SCANS + 1);
  localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_MAX    = CNT_W'(DEB_SCANS);
  localparam logic [1:0]       COL_LAST   = 2'(NUM_COLS - 1);

  // Synchronized rows
  logic [NUM_ROWS-1:0] w_rows;

  sync_2ff #(.WIDTH(NUM_ROWS)) u_row_sync (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_d    (i_key_in),
    .o_q    (w_rows)
  );

  // Scan / debounce state
  scan_state_t         r_state;
  logic [1:0]          r_col_idx;
  logic [DIV_W-1:0]    r_dwell;
  logic [NUM_KEYS-1:0] r_frame;
  logic [CODE_W-1:0]   r_cand;
  logic [CNT_W-1:0]    r_cnt;
  logic [CODE_W-1:0]   r_deb;
  logic [NUM_COLS-1:0] r_key_out;
  logic [CODE_W-1:0]   r_key_code;
  logic                r_key_valid;
  logic                r_key_held;

  // Row samples placed into the frame vector at the current column
  logic [NUM_COLS-1:0] w_col_onehot;
  logic [NUM_KEYS-1:0] w_sample_bits;

  assign w_col_onehot = NUM_COLS'(1) << r_col_idx;

  for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
    assign w_sample_bits[gi*NUM_COLS +: NUM_COLS] = w_rows[gi] ? w_col_onehot : '0;
  end

  // Frame encode: empty -> none, one bit -> its code, several -> multi
  logic [CODE_W-1:0] w_hit_idx;
  logic              w_frame_empty;
  logic              w_frame_single;
  logic [CODE_W-1:0] w_frame_code;

  always_comb begin
    w_hit_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (r_frame[i]) w_hit_idx = CODE_W'(i);
    end
    w_frame_empty  = (r_frame == '0);
    // Clearing the lowest set bit leaves zero only when at most one bit was set.
    w_frame_single = !w_frame_empty && ((r_frame & (r_frame - NUM_KEYS'(1))) == '0);
    if (w_frame_empty)       w_frame_code = KEY_NONE;
    else if (w_frame_single) w_frame_code = key_code_of(w_hit_idx);
    else                     w_frame_code = KEY_MULTI;
  end

  // Debounce next-state
  logic [CODE_W-1:0] w_cand_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_deb_change;
  logic              w_new_is_key;

  always_comb begin
    if (w_frame_code == r_cand) begin
      w_cand_next = r_cand;
      w_cnt_next  = (r_cnt == DEB_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    end else begin
      w_cand_next = w_frame_code;
      w_cnt_next  = CNT_W'(1);
    end
    w_deb_change = (w_cnt_next == DEB_MAX) && (w_cand_next != r_deb);
    w_new_is_key = (w_cand_next != KEY_NONE) && (w_cand_next != KEY_MULTI);
  end

  // The column drive is registered from the current state, so it lags the
  // dwell counter by one cycle; each column still shows for SCAN_DIV cycles
  // and the idle reset state drives nothing.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state     <= COL_DWELL;
      r_col_idx   <= '0;
      r_dwell     <= '0;
      r_frame     <= '0;
      r_cand      <= KEY_NONE;
      r_cnt       <= '0;
      r_deb       <= KEY_NONE;
      r_key_out   <= '0;
      r_key_code  <= KEY_NONE;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      case (r_state)
        COL_DWELL: begin
          r_key_out <= w_col_onehot;
          if (r_dwell == DWELL_LAST) begin
            r_frame <= r_frame | w_sample_bits;
            r_dwell <= '0;
            if (r_col_idx == COL_LAST) begin
              r_state <= FRAME_EVAL;
            end else begin
              r_col_idx <= r_col_idx + 2'd1;
            end
          end else begin
            r_dwell <= r_dwell + DIV_W'(1);
          end
        end
        FRAME_EVAL: begin
          r_key_out <= '0;
          r_frame   <= '0;
          r_col_idx <= '0;
          r_state   <= COL_DWELL;
          r_cand    <= w_cand_next;
          r_cnt     <= w_cnt_next;
          if (w_deb_change) begin
            r_deb <= w_cand_next;
            if (w_new_is_key) begin
              r_key_code  <= w_cand_next;
              r_key_valid <= 1'b1;
              r_key_held  <= 1'b1;
            end else begin
              r_key_held  <= 1'b0;
            end
          end
        end
        default: r_state <= COL_DWELL;
      endcase
    end
  end

  assign o_key_out   = r_key_out;
  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;
  assign o_key_held  = r_key_held;

endmodule

// File: tb/tb_key_scan.sv
// tb_key_scan
// Bench for key_scan with SCAN_DIV = 4, DEB_SCANS = 2 (17-cycle frames).
// A keypad matrix model reflects the closed-key set onto the rows for the driven
// column; a frame-level reference model predicts debounced outputs.
module tb_key_scan;

  localparam int SCAN_DIV  = 4;
  localparam int DEB_SCANS = 2;
  localparam int FRAME     = 4 * SCAN_DIV + 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [19:0] pressed = '0;
  logic [4:0]  key_rows;
  logic [3:0]  key_out;
  logic [4:0]  key_code;
  logic        key_valid;
  logic        key_held;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  key_scan #(.SCAN_DIV(SCAN_DIV), .DEB_SCANS(DEB_SCANS)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_key_in    (key_rows),
    .o_key_out   (key_out),
    .o_key_code  (key_code),
    .o_key_valid (key_valid),
    .o_key_held  (key_held)
  );

  // Keypad matrix: a row reads high when any closed key on it sits in a driven column.
  always_comb begin
    for (int r = 0; r < 5; r++) key_rows[r] = |(pressed[r*4 +: 4] & key_out);
  end

  // ---------------- reference model (frame level) ----------------
  int         hist[$];
  logic [4:0] m_deb, m_code;
  logic       m_held, m_pulse;

  function automatic logic [4:0] frame_code_of(input logic [19:0] k);
    int n;
    n = $countones(k);
    if (n == 0) return 5'd0;
    if (n > 1)  return 5'd31;
    for (int i = 0; i < 20; i++) if (k[i]) return 5'(i + 1);
    return 5'd0;
  endfunction

  // Column drive expected at position p (0..16) of a frame, p = 0 being the
  // cycle right after frame evaluation (or the reset-release cycle).
  function automatic logic [3:0] exp_out(input int p);
    if (p == 0) return 4'b0000;
    return 4'(1 << ((p - 1) / 4));
  endfunction

  task automatic model_reset();
    hist.delete();
    m_deb = 0; m_code = 0; m_held = 0; m_pulse = 0;
  endtask

  // The debounced state moves to a code once the last DEB_SCANS frames all showed it.
  task automatic model_frame(input logic [19:0] k);
    int  fc;
    bit  stable;
    fc = int'(frame_code_of(k));
    hist.push_back(fc);
    m_pulse = 0;
    if (hist.size() >= DEB_SCANS) begin
      stable = 1;
      for (int j = 1; j <= DEB_SCANS; j++) if (hist[hist.size() - j] != fc) stable = 0;
      if (stable && fc != int'(m_deb)) begin
        m_deb = 5'(fc);
        if (fc != 0 && fc != 31) begin
          m_code = 5'(fc); m_held = 1; m_pulse = 1;
        end else begin
          m_held = 0;
        end
      end
    end
  endtask

  // ---------------- stimulus / observation ----------------
  logic [4:0] obs_code;
  logic       obs_held, obs_valid;
  int         obs_extra, obs_out_bad, obs_pulses;

  // Call at the negedge of frame position 0; returns at position 0 of the next
  // frame with that frame's outcome captured.
  task automatic run_frame(input logic [19:0] keys);
    pressed = keys;
    model_frame(keys);
    obs_extra = 0;
    obs_out_bad = 0;
    for (int p = 1; p < FRAME; p++) begin
      @(negedge clk);
      if (key_valid) obs_extra++;
      if (key_out !== exp_out(p)) obs_out_bad++;
    end
    @(negedge clk);
    if (key_out !== 4'b0000) obs_out_bad++;
    obs_code  = key_code;
    obs_held  = key_held;
    obs_valid = key_valid;
    if (key_valid) obs_pulses++;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    pressed = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    pressed = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({key_out, key_code, key_valid, key_held} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: out=%b code=%0d valid=%b held=%b, expected all 0",
               key_out, key_code, key_valid, key_held);
    end
    rstn = 1'b1;
    for (int k = 1; k < 2 * FRAME + 1; k++) begin
      @(negedge clk);
      n_checks++;
      if (key_out !== exp_out(k % FRAME) || key_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_scan cycle %0d: out=%b valid=%b, expected out=%b valid=0",
                 k, key_out, key_valid, exp_out(k % FRAME));
      end
    end
    $display("test_reset done: checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_single_key();
    do_reset();
    obs_pulses = 0;
    for (int f = 0; f < 13; f++) begin
      run_frame(f < 10 ? 20'(1 << 11) : 20'd0);
      n_checks++;
      if ({obs_code, obs_held, obs_valid} !== {m_code, m_held, m_pulse} || obs_extra != 0 || obs_out_bad != 0) begin
        n_fail++;
        $display("FAIL single_key frame %0d: code=%0d held=%b valid=%b extra=%0d outbad=%0d, expected code=%0d held=%b valid=%b extra=0 outbad=0",
                 f, obs_code, obs_held, obs_valid, obs_extra, obs_out_bad, m_code, m_held, m_pulse);
      end
      if (f == 9) begin
        n_checks++;
        if (obs_pulses != 1 || obs_code !== 5'd12 || obs_held !== 1'b1) begin
          n_fail++;
          $display("FAIL key12_press: pulses=%0d code=%0d held=%b, expected pulses=1 code=12 held=1",
                   obs_pulses, obs_code, obs_held);
        end
      end
    end
    n_checks++;
    if (obs_pulses != 1 || obs_code !== 5'd12 || obs_held !== 1'b0) begin
      n_fail++;
      $display("FAIL key12_release: pulses=%0d code=%0d held=%b, expected pulses=1 code=12 held=0",
               obs_pulses, obs_code, obs_held);
    end
    $display("test_single_key done: pulses=%0d code=%0d", obs_pulses, obs_code);
  endtask

  task automatic test_bounce();
    obs_pulses = 0;
    for (int f = 0; f < 4; f++) begin
      run_frame(f == 0 ? 20'h00001 : 20'd0);
      n_checks++;
      if ({obs_code, obs_held, obs_valid} !== {m_code, m_held, m_pulse} || obs_extra != 0 || obs_out_bad != 0) begin
        n_fail++;
        $display("FAIL bounce frame %0d: code=%0d held=%b valid=%b extra=%0d outbad=%0d, expected code=%0d held=%b valid=%b",
                 f, obs_code, obs_held, obs_valid, obs_extra, obs_out_bad, m_code, m_held, m_pulse);
      end
    end
    n_checks++;
    if (obs_pulses != 0 || obs_held !== 1'b0 || obs_code !== 5'd12) begin
      n_fail++;
      $display("FAIL bounce_summary: pulses=%0d held=%b code=%0d, expected pulses=0 held=0 code=12",
               obs_pulses, obs_held, obs_code);
    end
    $display("test_bounce done: pulses=%0d", obs_pulses);
  endtask

  task automatic test_multi_key();
    obs_pulses = 0;
    for (int f = 0; f < 9; f++) begin
      run_frame(f < 6 ? (20'(1 << 4) | 20'(1 << 15)) : 20'd0);
      n_checks++;
      if ({obs_code, obs_held, obs_valid} !== {m_code, m_held, m_pulse} || obs_extra != 0 || obs_out_bad != 0 || obs_held !== 1'b0) begin
        n_fail++;
        $display("FAIL multi_key frame %0d: code=%0d held=%b valid=%b extra=%0d outbad=%0d, expected code=%0d held=0 valid=0",
                 f, obs_code, obs_held, obs_valid, obs_extra, obs_out_bad, m_code);
      end
    end
    n_checks++;
    if (obs_pulses != 0) begin
      n_fail++;
      $display("FAIL multi_key_pulses: pulses=%0d, expected 0", obs_pulses);
    end
    $display("test_multi_key done: pulses=%0d", obs_pulses);
  endtask

  task automatic test_back_to_back();
    logic [4:0] codes[$];
    obs_pulses = 0;
    for (int f = 0; f < 13; f++) begin
      run_frame(f < 5 ? 20'(1 << 4) : (f < 10 ? 20'(1 << 8) : 20'd0));
      if (obs_valid) codes.push_back(obs_code);
      n_checks++;
      if ({obs_code, obs_held, obs_valid} !== {m_code, m_held, m_pulse} || obs_extra != 0 || obs_out_bad != 0) begin
        n_fail++;
        $display("FAIL slide frame %0d: code=%0d held=%b valid=%b extra=%0d outbad=%0d, expected code=%0d held=%b valid=%b",
                 f, obs_code, obs_held, obs_valid, obs_extra, obs_out_bad, m_code, m_held, m_pulse);
      end
    end
    n_checks++;
    if (codes.size() != 2 || codes[0] !== 5'd5 || codes[1] !== 5'd9) begin
      n_fail++;
      $display("FAIL slide_codes: pulses=%0d first=%0d second=%0d, expected pulses=2 codes 5 then 9",
               codes.size(), codes.size() > 0 ? codes[0] : 5'd0, codes.size() > 1 ? codes[1] : 5'd0);
    end
    $display("test_back_to_back done: pulses=%0d", codes.size());
  endtask

  task automatic test_random();
    logic [19:0] keys;
    int kind, len, a, b, nframes;
    nframes = 0;
    for (int s = 0; s < 30; s++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 4);
      a    = $urandom_range(0, 19);
      b    = (a + 1 + $urandom_range(0, 18)) % 20;
      if (kind <= 5)      keys = 20'(1 << a);
      else if (kind <= 7) keys = '0;
      else                keys = 20'(1 << a) | 20'(1 << b);
      for (int f = 0; f < len; f++) begin
        run_frame(keys);
        nframes++;
        n_checks++;
        if ({obs_code, obs_held, obs_valid} !== {m_code, m_held, m_pulse} || obs_extra != 0 || obs_out_bad != 0) begin
          n_fail++;
          $display("FAIL random seg %0d keys=%h: code=%0d held=%b valid=%b extra=%0d outbad=%0d, expected code=%0d held=%b valid=%b",
                   s, keys, obs_code, obs_held, obs_valid, obs_extra, obs_out_bad, m_code, m_held, m_pulse);
        end
      end
    end
    $display("test_random done: frames=%0d", nframes);
  endtask

  task automatic test_reset_midframe();
    for (int f = 0; f < 3; f++) begin
      run_frame(20'(1 << 19));
      n_checks++;
      if ({obs_code, obs_held, obs_valid} !== {m_code, m_held, m_pulse} || obs_extra != 0 || obs_out_bad != 0) begin
        n_fail++;
        $display("FAIL pre_reset frame %0d: code=%0d held=%b valid=%b, expected code=%0d held=%b valid=%b",
                 f, obs_code, obs_held, obs_valid, m_code, m_held, m_pulse);
      end
    end
    repeat (6) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({key_out, key_code, key_valid, key_held} !== 11'd0) begin
      n_fail++;
      $display("FAIL midframe_reset_clear: out=%b code=%0d valid=%b held=%b, expected all 0",
               key_out, key_code, key_valid, key_held);
    end
    rstn = 1'b1;
    model_reset();
    obs_pulses = 0;
    for (int f = 0; f < 3; f++) begin
      run_frame(20'(1 << 19));
      n_checks++;
      if ({obs_code, obs_held, obs_valid} !== {m_code, m_held, m_pulse} || obs_extra != 0 || obs_out_bad != 0) begin
        n_fail++;
        $display("FAIL post_reset frame %0d: code=%0d held=%b valid=%b extra=%0d outbad=%0d, expected code=%0d held=%b valid=%b",
                 f, obs_code, obs_held, obs_valid, obs_extra, obs_out_bad, m_code, m_held, m_pulse);
      end
    end
    n_checks++;
    if (obs_pulses != 1 || obs_code !== 5'd20 || obs_held !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_press: pulses=%0d code=%0d held=%b, expected pulses=1 code=20 held=1",
               obs_pulses, obs_code, obs_held);
    end
    $display("test_reset_midframe done: pulses=%0d code=%0d", obs_pulses, obs_code);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_key();
    test_bounce();
    test_multi_key();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_scan.md
# key_scan

Matrix-keypad scanner for the timer design. It drives the 4 keypad column lines one at a time and reads back the 5 row lines. From those samples it builds a frame key code each scan, debounces it over several scan frames, and reports debounced presses to the timer control logic. It is the driving end of the column/row keypad interface: the keypad matrix responds on the rows to whichever column is asserted.

## Interface
- SCAN_DIV, 10000, clock cycles each column is asserted (1 ms at 10 MHz); must be ≥ 4
- DEB_SCANS, 3, consecutive identical frame codes required to change the debounced state; must be ≥ 1
- i_clk  input  1  system clock, rising edge
- i_rstn  input  1  reset, synchronous, active-low
- i_key_in  input  5  row lines; bit r high = a key in row r of the asserted column is closed
- o_key_out  output  4  column drive, one-hot active-high, bit c = column c
- o_key_code  output  5  last debounced key code, 1..20; 0 until the first press
- o_key_valid  output  1  one-cycle pulse on a debounced press
- o_key_held  output  1  high while the debounced state is a single valid key

## Operation
- Row input passes through a 2-flop synchronizer before any use.
- Key code = r*4 + c + 1 for row r (0..4) and column c (0..3). Range 1..20; 0 = none.
- Scan FSM has two states:
  - COL_DWELL: col_idx 0..3, dwell counter 0..SCAN_DIV-1; o_key_out = 1<<col_idx.
    - On dwell == SCAN_DIV-1, the synchronized rows are OR-merged into a 20-bit frame vector at column col_idx.
    - If col_idx < 3, col_idx increments and dwell resets. If col_idx == 3, the FSM goes to FRAME_EVAL.
  - FRAME_EVAL: lasts one cycle; o_key_out = 0.
    - Frame code = 0 if the vector is empty, the key code if exactly one bit is set, KEY_MULTI (31) if more than one bit is set.
    - The vector is cleared, col_idx = 0, and the FSM returns to COL_DWELL.
- Debounce is evaluated in FRAME_EVAL:
  - If the frame code equals the candidate code, the count increments, saturating at DEB_SCANS.
  - Otherwise, candidate = frame code and count = 1.
  - When the count reaches DEB_SCANS and candidate ≠ debounced state, the debounced state takes the candidate.
- Effects of a debounced-state change:
  - To 1..20: o_key_code is updated, o_key_valid pulses and o_key_held = 1. A direct key-to-key slide also pulses.
  - To 0 or KEY_MULTI: o_key_held = 0, o_key_code holds its value, no pulse.
- An unchanged debounced state never re-pulses, however long the key is held (no auto-repeat).
- Reset values: o_key_out = 0, o_key_code = 0, o_key_valid = 0, o_key_held = 0. FSM = COL_DWELL, col_idx = 0, dwell = 0. Frame vector, candidate, count and debounced state all 0. Synchronizer flops = 0.

## Timing
- The first cycle after reset release drives o_key_out = 4'b0001.
- Frame length = 4*SCAN_DIV + 1 cycles.
- A row sample taken at dwell == SCAN_DIV-1 reflects i_key_in from 2 cycles earlier, so rows have SCAN_DIV-3 cycles to settle after a column switch.
- o_key_code, o_key_valid and o_key_held are registered and change in the cycle after the deciding FRAME_EVAL.
- o_key_valid is high for exactly that one cycle.
- Press latency ≤ (DEB_SCANS+1) frames + 1 cycle. Release latency is the same bound.
- A frame with a partial press (key closed for only some columns' samples) counts whatever was sampled. No special handling.
- Reset asserted mid-frame or mid-debounce discards all state on the next edge. A key still held after release must debounce again and produces a fresh pulse.

## Structure
- key_scan_pkg holds:
  - constants NUM_COLS = 4, NUM_ROWS = 5, KEY_NONE = 5'd0, KEY_MULTI = 5'd31
  - scan state enum {COL_DWELL, FRAME_EVAL}
  - the key-code width (5)
- One sub-module: sync_2ff, a parameterized-width 2-flop synchronizer used for i_key_in.
- Frame encode (popcount ≤ 1 check plus index-to-code) and debounce stay inline in key_scan.

## Test plan
Bench runs SCAN_DIV = 4, DEB_SCANS = 2 (frame = 17 cycles), with a behavioural matrix model that reflects closed keys onto the rows for the asserted column.
- Reset, then idle → all outputs 0 during reset. Then o_key_out = 0001, 0010, 0100, 1000 for 4 cycles each, then 0000 for 1 cycle, repeating. No valid pulses.
- Key r=2, c=3 held 10 frames → exactly one o_key_valid pulse with o_key_code = 12 and o_key_held = 1. On release, o_key_held falls within 3 frames, o_key_code stays 12, no pulse.
- Key r=0, c=0 closed for 1 frame only (bounce) → no pulse, o_key_held stays 0, o_key_code unchanged.
- Keys 5 and 16 closed together for 6 frames → no pulse, o_key_held = 0.
- Key 5 held 5 frames, then slides directly to key 9 held 5 frames → two pulses, codes 5 then 9. o_key_held stays 1 throughout except during the transition frames.
- Key 20 (r=4, c=3) held while i_rstn is pulsed low for 1 cycle mid-frame → outputs clear, scan restarts at column 0, and a new pulse with code 20 arrives within 3 frames.
